// File: rtl/ifm_row_fetch.sv
// -----------------------------------------------------------------------------
// ifm_row_fetch
//
// Fetches a rectangular tile of input-feature-map words from a fixed-latency
// read-only RAM and streams them downstream with valid/ready handshaking.
// A tile is num_rows rows of row_len consecutive words; successive row starts
// are row_stride apart. Reads are issued only when a slot is guaranteed in the
// output buffer for the returning word, so the buffer can never overflow and
// the RAM never needs to be back-pressured.
//
// Ports
//   clk, rst_n     clock (rising edge) and synchronous active-low reset
//   start          one-cycle launch pulse, honoured only while idle
//   base_addr      address of the first word of the tile
//   row_len        words per row
//   num_rows       rows per tile
//   row_stride     address step between row starts
//   ram_rd_req     read strobe to the ifmap RAM
//   ram_rd_addr    read address (wraps modulo 2^ADDR_WIDTH)
//   ram_rd_data    read data, valid RD_LATENCY cycles after ram_rd_req
//   m_valid        output word available
//   m_ready        downstream accepts the word this cycle
//   m_data         output word
//   m_last         final word of a row
//   busy           a tile fetch is in progress
//   done           one-cycle pulse after the last word of a tile is accepted
//                  (or after a start with an empty tile)
// -----------------------------------------------------------------------------
module ifm_row_fetch #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_len,
    input  logic [7:0]            num_rows,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    output logic                  ram_rd_req,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam int IF_W   = $clog2(RD_LATENCY + 1);
    // Wide enough to hold in_flight + fifo_count without overflow.
    localparam int CRD_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } fifo_word_t;

    state_t state, state_next;

    // Tile parameters captured at start.
    logic [ADDR_WIDTH-1:0] row_len_q;
    logic [7:0]            num_rows_q;
    logic [ADDR_WIDTH-1:0] row_stride_q;

    // Issue-side address generation.
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] col;
    logic [7:0]            row;
    logic                  col_at_end;
    logic                  row_at_end;
    logic                  issue;
    logic                  start_zero;

    // Requests in flight through the RAM, each tagged with its row-end flag.
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] last_pipe;
    logic [IF_W-1:0]       in_flight;
    logic                  credit_ok;

    // Output buffer.
    fifo_word_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  push;
    logic                  pop;
    logic                  final_pop;
    fifo_word_t            head;

    assign start_zero = (row_len == '0) || (num_rows == '0);
    assign col_at_end = (col == row_len_q - ADDR_WIDTH'(1));
    assign row_at_end = (row == num_rows_q - 8'd1);

    assign in_flight  = IF_W'($countones(vld_pipe));
    assign credit_ok  = (CRD_W'(in_flight) + CRD_W'(fifo_count)) < CRD_W'(FIFO_DEPTH);

    // A returning word lands in the buffer exactly RD_LATENCY cycles after
    // its request, which is when its valid bit reaches the end of the pipe.
    assign push       = vld_pipe[RD_LATENCY-1];
    assign pop        = m_valid && m_ready;
    assign final_pop  = pop && (fifo_count == FCNT_W'(1)) && (in_flight == '0);

    assign head       = fifo_mem[rd_ptr];
    assign m_valid    = (fifo_count != '0);
    // Gating with m_valid keeps the stream outputs at zero out of reset even
    // though the buffer storage itself holds stale contents.
    assign m_data     = m_valid ? head.data : '0;
    assign m_last     = m_valid && head.last;

    assign ram_rd_req = issue;
    assign busy       = (state != IDLE);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and issue outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        issue       = 1'b0;
        ram_rd_addr = '0;
        unique case (state)
            IDLE: begin
                if (start && !start_zero) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                ram_rd_addr = row_base + col;
                issue       = credit_ok;
                if (credit_ok && col_at_end && row_at_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (final_pop) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Tile parameters, address counters, in-flight pipe, buffer pointers, done
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_len_q    <= '0;
            num_rows_q   <= '0;
            row_stride_q <= '0;
            row_base     <= '0;
            col          <= '0;
            row          <= '0;
            vld_pipe     <= '0;
            last_pipe    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            done         <= 1'b0;
        end else begin
            done <= ((state == IDLE) && start && start_zero) ||
                    ((state == DRAIN) && final_pop);

            if ((state == IDLE) && start) begin
                row_len_q    <= row_len;
                num_rows_q   <= num_rows;
                row_stride_q <= row_stride;
                row_base     <= base_addr;
                col          <= '0;
                row          <= '0;
            end else if (issue) begin
                if (col_at_end) begin
                    col      <= '0;
                    row_base <= row_base + row_stride_q;
                    row      <= row + 8'd1;
                end else begin
                    col <= col + ADDR_WIDTH'(1);
                end
            end

            vld_pipe[0]  <= issue;
            last_pipe[0] <= issue && col_at_end;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the buffer storage is deliberately left without reset; occupancy is
    // governed entirely by the pointers and count, which are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{last: last_pipe[RD_LATENCY-1], data: ram_rd_data};
        end
    end

endmodule

// File: tb/tb_ifm_row_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifm_row_fetch
//
// Directed bench for ifm_row_fetch. A behavioural RAM answers every request
// RD_LATENCY cycles later with a word derived from its address; a negedge
// monitor records issued addresses and accepted words, and each tile is
// compared against the expected address/word list built from its parameters.
// -----------------------------------------------------------------------------
module tb_ifm_row_fetch;

    localparam int DW    = 10;
    localparam int AW    = 12;
    localparam int L     = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] row_len;
    logic [7:0]    num_rows;
    logic [AW-1:0] row_stride;
    logic          ram_rd_req;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifm_row_fetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (L),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .row_len     (row_len),
        .num_rows    (num_rows),
        .row_stride  (row_stride),
        .ram_rd_req  (ram_rd_req),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        int t;
        t = int'(a) * 7 + 1;
        return t[DW-1:0];
    endfunction

    // RAM model: not reset, so words for pre-reset requests still come back.
    logic          req_d  [L];
    logic [AW-1:0] addr_d [L];

    initial begin
        for (int i = 0; i < L; i++) begin
            req_d[i]  = 1'b0;
            addr_d[i] = '0;
        end
    end

    always @(posedge clk) begin
        req_d[0]  <= ram_rd_req;
        addr_d[0] <= ram_rd_addr;
        for (int i = 1; i < L; i++) begin
            req_d[i]  <= req_d[i-1];
            addr_d[i] <= addr_d[i-1];
        end
    end

    assign ram_rd_data = req_d[L-1] ? ram_word(addr_d[L-1]) : 10'h2AA;

    // Monitor.
    logic [AW-1:0] rd_q [$];
    logic [DW:0]   out_q [$];
    int            done_cnt;
    int            busy_seen;
    int            stable_err;
    int            max_out;
    logic          prev_stall;
    logic [DW:0]   prev_word;

    always @(negedge clk) begin
        if (rst_n && ram_rd_req) rd_q.push_back(ram_rd_addr);
        if (busy) busy_seen++;
        if (done) done_cnt++;
        if (prev_stall && !(m_valid && ({m_last, m_data} == prev_word))) stable_err++;
        prev_stall = rst_n && m_valid && !m_ready;
        prev_word  = {m_last, m_data};
        if (rst_n && m_valid && m_ready) out_q.push_back({m_last, m_data});
        if (rd_q.size() - out_q.size() > max_out) max_out = rd_q.size() - out_q.size();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        out_q.delete();
        done_cnt   = 0;
        busy_seen  = 0;
        stable_err = 0;
        max_out    = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] len,
                               input logic [7:0] rows, input logic [AW-1:0] stride);
        @(posedge clk); #1;
        base_addr  = b;
        row_len    = len;
        num_rows   = rows;
        row_stride = stride;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // mode 0: always ready; 1: not ready for stall_cycles, then ready; 2: random.
    task automatic run_until_done(input string tag, input int mode, input int stall_cycles,
                                  input int budget);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc >= stall_cycles);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 1 && cyc == stall_cycles) begin
                check({tag, "_stall_reads"}, rd_q.size(), DEPTH);
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check({tag, "_done_once"}, done_cnt, 1);
    endtask

    task automatic verify_tile(input string tag, input logic [AW-1:0] b, input logic [AW-1:0] len,
                               input int rows, input logic [AW-1:0] stride);
        int          n;
        int          k;
        int          lasts;
        logic [AW-1:0] a;
        logic [AW-1:0] rr;
        logic [AW-1:0] cc;
        logic [DW:0]   w;
        n = int'(len) * rows;
        check({tag, "_nreads"}, rd_q.size(), n);
        check({tag, "_nwords"}, out_q.size(), n);
        k = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < int'(len); c++) begin
                rr = AW'(r);
                cc = AW'(c);
                a  = b + rr * stride + cc;
                w  = {(c == int'(len) - 1), ram_word(a)};
                if (k < rd_q.size())  check($sformatf("%s_addr%0d", tag, k), rd_q[k], a);
                if (k < out_q.size()) check($sformatf("%s_word%0d", tag, k), out_q[k], w);
                k++;
            end
        end
        lasts = 0;
        foreach (out_q[i]) lasts += int'(out_q[i][DW]);
        check({tag, "_lasts"}, lasts, rows);
        check({tag, "_stable"}, stable_err, 0);
        check({tag, "_credit"}, (max_out <= DEPTH), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        row_len    = '0;
        num_rows   = '0;
        row_stride = '0;
        m_ready    = 1'b0;
        clear_mon();
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Reset values.
        check("rst_req",    ram_rd_req,  0);
        check("rst_addr",   ram_rd_addr, 0);
        check("rst_valid",  m_valid,     0);
        check("rst_data",   m_data,      0);
        check("rst_last",   m_last,      0);
        check("rst_busy",   busy,        0);
        check("rst_done",   done,        0);
        rst_n = 1'b1;

        // Basic tile, always ready; a start with other parameters while busy
        // must be ignored.
        clear_mon();
        m_ready = 1'b1;
        pulse_start(12'h010, 12'd4, 8'd2, 12'h020);
        check("basic_busy", busy, 1);
        base_addr = 12'h500;
        row_len   = 12'd1;
        num_rows  = 8'd1;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        run_until_done("basic", 0, 0, 200);
        verify_tile("basic", 12'h010, 12'd4, 2, 12'h020);
        check("basic_idle", busy, 0);

        // Same tile with downstream stalled for 20 cycles.
        clear_mon();
        pulse_start(12'h010, 12'd4, 8'd2, 12'h020);
        run_until_done("stall", 1, 20, 200);
        verify_tile("stall", 12'h010, 12'd4, 2, 12'h020);

        // Address wrap at the top of the address space.
        clear_mon();
        pulse_start(12'hFFE, 12'd4, 8'd1, 12'h000);
        run_until_done("wrap", 0, 0, 200);
        verify_tile("wrap", 12'hFFE, 12'd4, 1, 12'h000);

        // Empty tiles: done the next cycle, no reads, never busy.
        clear_mon();
        pulse_start(12'h010, 12'd0, 8'd3, 12'h001);
        check("zlen_done", done, 1);
        check("zlen_busy", busy, 0);
        @(posedge clk); #1;
        check("zlen_done_pulse", done, 0);
        pulse_start(12'h010, 12'd5, 8'd0, 12'h001);
        check("zrow_done", done, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("zero_reads", rd_q.size(), 0);
        check("zero_done_cnt", done_cnt, 2);
        check("zero_busy_seen", busy_seen, 0);

        // Reset in the middle of issuing with two reads in flight.
        clear_mon();
        m_ready = 1'b1;
        pulse_start(12'h100, 12'd8, 8'd2, 12'h040);
        for (int i = 0; i < 10 && rd_q.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        check("mid_reads_before_rst", rd_q.size(), 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_busy",  busy,    0);
        check("mid_rst_req",   ram_rd_req, 0);
        rst_n = 1'b1;
        clear_mon();
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("mid_stale_words", out_q.size(), 0);
        check("mid_stale_reads", rd_q.size(),  0);

        // Random backpressure on a 7x3 tile.
        clear_mon();
        pulse_start(12'h200, 12'd7, 8'd3, 12'h010);
        run_until_done("rand", 2, 0, 400);
        verify_tile("rand", 12'h200, 12'd7, 3, 12'h010);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
